vanilla_sb_clear_arbiter: RTL and testbench

Scoreboard-clear arbiter for the vanilla core. It collects scoreboard-clear requests from several completion sources, such as remote-load returns, the idiv unit and the fdiv/fsqrt unit. It buffers them per source and issues at most one integer clear and one float clear per cycle. Its outputs drive the int/float `sb_clear` / `sb_clear_id` inputs of the scoreboard and scoreboard tracker. Arbitration is round-robin within each register-file pool, so no source starves.

---
 rtl/vanilla_sb_clear_arbiter.sv | 146 ++++++++++++++
 tb/tb_vanilla_sb_clear_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vanilla_sb_clear_arbiter.sv
// Scoreboard-clear arbiter: per-source clear FIFOs feeding independent round-robin
// int and float arbiters, each issuing at most one registered clear per cycle.
module vanilla_sb_clear_arbiter #(
  parameter int num_src_p        = 3,
  parameter int reg_addr_width_p = 5,
  parameter int fifo_els_p       = 2
) (
  input  logic                                         clk_i,
  input  logic                                         reset_n_i,
  input  logic [num_src_p-1:0]                         src_v_i,
  input  logic [num_src_p-1:0]                         src_is_float_i,
  input  logic [num_src_p-1:0][reg_addr_width_p-1:0]   src_id_i,
  output logic [num_src_p-1:0]                         src_ready_o,
  output logic                                         int_sb_clear_o,
  output logic [reg_addr_width_p-1:0]                  int_sb_clear_id_o,
  output logic                                         float_sb_clear_o,
  output logic [reg_addr_width_p-1:0]                  float_sb_clear_id_o,
  output logic                                         pending_o
);

  localparam int entry_w_lp = reg_addr_width_p + 1;
  localparam int ptr_w_lp   = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w_lp   = $clog2(fifo_els_p + 1);
  localparam int idx_w_lp   = $clog2(num_src_p);

  logic [entry_w_lp-1:0] mem_r    [num_src_p][fifo_els_p];
  logic [ptr_w_lp-1:0]   rd_ptr_r [num_src_p];
  logic [ptr_w_lp-1:0]   wr_ptr_r [num_src_p];
  logic [cnt_w_lp-1:0]   cnt_r    [num_src_p];
  logic [cnt_w_lp-1:0]   cnt_nxt_s[num_src_p];
  logic [entry_w_lp-1:0] head_s   [num_src_p];

  logic [num_src_p-1:0] full_s, nonempty_s, enq_s, deq_s;
  logic [num_src_p-1:0] int_req_s, float_req_s, int_gnt_s, float_gnt_s;
  logic [idx_w_lp:0]    int_pick_s, float_pick_s;
  logic [idx_w_lp-1:0]  int_rr_r, float_rr_r;

  logic                        int_clear_r, float_clear_r;
  logic [reg_addr_width_p-1:0] int_id_r, float_id_r;

  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_w_lp'(fifo_els_p - 1)) return '0;
    else return p + ptr_w_lp'(1);
  endfunction

  function automatic logic [idx_w_lp-1:0] next_rr(input logic [idx_w_lp-1:0] g);
    if (g == idx_w_lp'(num_src_p - 1)) return '0;
    else return g + idx_w_lp'(1);
  endfunction

  // Returns {valid, index}; scanning from the far end lets the lowest offset from rr win.
  function automatic logic [idx_w_lp:0] rr_pick(input logic [num_src_p-1:0] req,
                                                input logic [idx_w_lp-1:0]  rr);
    logic [idx_w_lp:0] res;
    int cand;
    res = '0;
    for (int off = num_src_p - 1; off >= 0; off--) begin
      cand = int'(rr) + off;
      if (cand >= num_src_p) cand = cand - num_src_p;
      if (req[idx_w_lp'(cand)]) res = {1'b1, idx_w_lp'(cand)};
      else res = res;
    end
    return res;
  endfunction

  // Per-source FIFO status, head decode and enqueue qualification (int x0 is dropped).
  always_comb begin
    for (int i = 0; i < num_src_p; i++) begin
      full_s[i]      = (cnt_r[i] == cnt_w_lp'(fifo_els_p));
      nonempty_s[i]  = (cnt_r[i] != '0);
      head_s[i]      = mem_r[i][rd_ptr_r[i]];
      int_req_s[i]   = nonempty_s[i] & ~head_s[i][entry_w_lp-1];
      float_req_s[i] = nonempty_s[i] &  head_s[i][entry_w_lp-1];
      enq_s[i]       = src_v_i[i] & ~full_s[i]
                       & (src_is_float_i[i] | (src_id_i[i] != '0));
    end
  end

  // Round-robin grants for both pools and the resulting dequeues.
  always_comb begin
    int_pick_s   = rr_pick(int_req_s, int_rr_r);
    float_pick_s = rr_pick(float_req_s, float_rr_r);
    int_gnt_s    = '0;
    float_gnt_s  = '0;
    if (int_pick_s[idx_w_lp]) int_gnt_s[int_pick_s[idx_w_lp-1:0]] = 1'b1;
    else int_gnt_s = '0;
    if (float_pick_s[idx_w_lp]) float_gnt_s[float_pick_s[idx_w_lp-1:0]] = 1'b1;
    else float_gnt_s = '0;
    deq_s = int_gnt_s | float_gnt_s;
    for (int i = 0; i < num_src_p; i++) begin
      cnt_nxt_s[i] = cnt_r[i] + cnt_w_lp'(enq_s[i]) - cnt_w_lp'(deq_s[i]);
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_src_p; i++) begin
        rd_ptr_r[i] <= '0;
        wr_ptr_r[i] <= '0;
        cnt_r[i]    <= '0;
        for (int j = 0; j < fifo_els_p; j++) mem_r[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < num_src_p; i++) begin
        if (enq_s[i]) begin
          mem_r[i][wr_ptr_r[i]] <= {src_is_float_i[i], src_id_i[i]};
          wr_ptr_r[i]           <= next_ptr(wr_ptr_r[i]);
        end
        if (deq_s[i]) rd_ptr_r[i] <= next_ptr(rd_ptr_r[i]);
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Round-robin pointers and registered clear outputs; ids hold when idle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      int_rr_r      <= '0;
      float_rr_r    <= '0;
      int_clear_r   <= 1'b0;
      float_clear_r <= 1'b0;
      int_id_r      <= '0;
      float_id_r    <= '0;
    end else begin
      int_clear_r   <= int_pick_s[idx_w_lp];
      float_clear_r <= float_pick_s[idx_w_lp];
      if (int_pick_s[idx_w_lp]) begin
        int_rr_r <= next_rr(int_pick_s[idx_w_lp-1:0]);
        int_id_r <= head_s[int_pick_s[idx_w_lp-1:0]][reg_addr_width_p-1:0];
      end
      if (float_pick_s[idx_w_lp]) begin
        float_rr_r <= next_rr(float_pick_s[idx_w_lp-1:0]);
        float_id_r <= head_s[float_pick_s[idx_w_lp-1:0]][reg_addr_width_p-1:0];
      end
    end
  end

  assign src_ready_o         = ~full_s;
  assign pending_o           = |nonempty_s;
  assign int_sb_clear_o      = int_clear_r;
  assign int_sb_clear_id_o   = int_id_r;
  assign float_sb_clear_o    = float_clear_r;
  assign float_sb_clear_id_o = float_id_r;

endmodule

// File: tb/tb_vanilla_sb_clear_arbiter.sv
// Directed bench for vanilla_sb_clear_arbiter with default parameters (3 sources, depth 2).
module tb_vanilla_sb_clear_arbiter;

  logic            clk_i;
  logic            reset_n_i;
  logic [2:0]      src_v_i;
  logic [2:0]      src_is_float_i;
  logic [2:0][4:0] src_id_i;
  logic [2:0]      src_ready_o;
  logic            int_sb_clear_o;
  logic [4:0]      int_sb_clear_id_o;
  logic            float_sb_clear_o;
  logic [4:0]      float_sb_clear_id_o;
  logic            pending_o;

  int total_cnt = 0;
  int bad_cnt   = 0;

  vanilla_sb_clear_arbiter dut (
    .clk_i               (clk_i),
    .reset_n_i           (reset_n_i),
    .src_v_i             (src_v_i),
    .src_is_float_i      (src_is_float_i),
    .src_id_i            (src_id_i),
    .src_ready_o         (src_ready_o),
    .int_sb_clear_o      (int_sb_clear_o),
    .int_sb_clear_id_o   (int_sb_clear_id_o),
    .float_sb_clear_o    (float_sb_clear_o),
    .float_sb_clear_id_o (float_sb_clear_id_o),
    .pending_o           (pending_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    src_v_i        = 3'b000;
    src_is_float_i = 3'b000;
    src_id_i       = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n_i = 1'b0;
    step();
    reset_n_i = 1'b1;
  endtask

  initial begin
    idle_inputs();
    reset_n_i = 1'b1;
    #2;
    do_reset();

    // Reset state
    check_eq("rst_int_clr",   {31'd0, int_sb_clear_o},   32'd0);
    check_eq("rst_flt_clr",   {31'd0, float_sb_clear_o}, 32'd0);
    check_eq("rst_int_id",    {27'd0, int_sb_clear_id_o},   32'd0);
    check_eq("rst_flt_id",    {27'd0, float_sb_clear_id_o}, 32'd0);
    check_eq("rst_pending",   {31'd0, pending_o},   32'd0);
    check_eq("rst_ready",     {29'd0, src_ready_o}, 32'd7);

    // Single int: two-cycle latency, one-cycle pulse, id held afterwards
    src_v_i = 3'b001; src_id_i[0] = 5'd5;
    step();
    idle_inputs();
    check_eq("single_early_clr", {31'd0, int_sb_clear_o}, 32'd0);
    check_eq("single_pending",   {31'd0, pending_o},      32'd1);
    step();
    check_eq("single_clr",     {31'd0, int_sb_clear_o},     32'd1);
    check_eq("single_id",      {27'd0, int_sb_clear_id_o},  32'd5);
    check_eq("single_flt_clr", {31'd0, float_sb_clear_o},   32'd0);
    check_eq("single_drained", {31'd0, pending_o},          32'd0);
    step();
    check_eq("single_pulse_end", {31'd0, int_sb_clear_o},    32'd0);
    check_eq("single_id_hold",   {27'd0, int_sb_clear_id_o}, 32'd5);

    // Round-robin from rr=0 over ids 1/2/3
    do_reset();
    src_v_i = 3'b111; src_id_i[0] = 5'd1; src_id_i[1] = 5'd2; src_id_i[2] = 5'd3;
    step();
    idle_inputs();
    step();
    check_eq("rr_clr0", {31'd0, int_sb_clear_o},    32'd1);
    check_eq("rr_id0",  {27'd0, int_sb_clear_id_o}, 32'd1);
    step();
    check_eq("rr_clr1", {31'd0, int_sb_clear_o},    32'd1);
    check_eq("rr_id1",  {27'd0, int_sb_clear_id_o}, 32'd2);
    step();
    check_eq("rr_clr2", {31'd0, int_sb_clear_o},    32'd1);
    check_eq("rr_id2",  {27'd0, int_sb_clear_id_o}, 32'd3);
    step();
    check_eq("rr_done", {31'd0, int_sb_clear_o}, 32'd0);
    // rr is back at 0: source 0 beats source 2
    src_v_i = 3'b101; src_id_i[0] = 5'd10; src_id_i[2] = 5'd12;
    step();
    idle_inputs();
    step();
    check_eq("rr_wrap_id0", {27'd0, int_sb_clear_id_o}, 32'd10);
    step();
    check_eq("rr_wrap_clr1", {31'd0, int_sb_clear_o},    32'd1);
    check_eq("rr_wrap_id1",  {27'd0, int_sb_clear_id_o}, 32'd12);

    // Parallel pools: float 4 from source 0, int 9 from source 2
    do_reset();
    src_v_i = 3'b101; src_is_float_i = 3'b001; src_id_i[0] = 5'd4; src_id_i[2] = 5'd9;
    step();
    idle_inputs();
    step();
    check_eq("par_int_clr", {31'd0, int_sb_clear_o},      32'd1);
    check_eq("par_int_id",  {27'd0, int_sb_clear_id_o},   32'd9);
    check_eq("par_flt_clr", {31'd0, float_sb_clear_o},    32'd1);
    check_eq("par_flt_id",  {27'd0, float_sb_clear_id_o}, 32'd4);

    // Backpressure on source 1 while sources 0 and 2 keep the int pool busy
    do_reset();
    src_v_i = 3'b111; src_id_i[0] = 5'd20; src_id_i[1] = 5'd21; src_id_i[2] = 5'd22;
    step();
    src_id_i[0] = 5'd23; src_id_i[1] = 5'd24; src_id_i[2] = 5'd25;
    step();
    check_eq("bp_ready_full", {29'd0, src_ready_o},       32'd1);
    check_eq("bp_id20",       {27'd0, int_sb_clear_id_o}, 32'd20);
    src_v_i = 3'b010; src_id_i[1] = 5'd26;
    step();
    check_eq("bp_id21",        {27'd0, int_sb_clear_id_o}, 32'd21);
    check_eq("bp_ready_freed", {29'd0, src_ready_o},       32'd3);
    step();
    check_eq("bp_id22", {27'd0, int_sb_clear_id_o}, 32'd22);
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("bp_seq_clr", {31'd0, int_sb_clear_o},    32'd1);
      check_eq("bp_seq_id",  {27'd0, int_sb_clear_id_o}, 32'd23 + 32'(k));
    end
    check_eq("bp_pending", {31'd0, pending_o}, 32'd0);
    step();
    check_eq("bp_end_clr", {31'd0, int_sb_clear_o}, 32'd0);

    // x0 filter: int id 0 is swallowed, float id 0 is cleared
    src_v_i = 3'b100; src_id_i[2] = 5'd0;
    step();
    idle_inputs();
    check_eq("x0_int_pending", {31'd0, pending_o},   32'd0);
    check_eq("x0_int_ready",   {29'd0, src_ready_o}, 32'd7);
    step();
    check_eq("x0_int_noclr", {31'd0, int_sb_clear_o}, 32'd0);
    src_v_i = 3'b100; src_is_float_i = 3'b100; src_id_i[2] = 5'd0;
    step();
    idle_inputs();
    check_eq("x0_flt_pending", {31'd0, pending_o}, 32'd1);
    step();
    check_eq("x0_flt_clr", {31'd0, float_sb_clear_o},    32'd1);
    check_eq("x0_flt_id",  {27'd0, float_sb_clear_id_o}, 32'd0);

    // Reset mid-stream discards a buffered clear
    src_v_i = 3'b010; src_id_i[1] = 5'd7;
    step();
    idle_inputs();
    check_eq("mid_pending_pre", {31'd0, pending_o}, 32'd1);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_eq("mid_async_pending", {31'd0, pending_o}, 32'd0);
    step();
    reset_n_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("mid_no_clr",  {31'd0, int_sb_clear_o}, 32'd0);
      check_eq("mid_ready",   {29'd0, src_ready_o},    32'd7);
      check_eq("mid_pending", {31'd0, pending_o},      32'd0);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
